tx_symbol_scheduler: RTL and testbench

TX_SYMBOL_SCHEDULER -- requirements
Module: tx_symbol_scheduler

---
 rtl/tx_symbol_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_tx_symbol_scheduler.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_symbol_scheduler.sv
// Transmit symbol scheduler feeding an 8b/10b encoder.
// It emits one symbol per clock. Each symbol comes from one of four sources:
// - packet data bytes from an upstream ready/valid source,
// - periodic SKP ordered sets (COM followed by SKP_COUNT SKP symbols),
// - on-request TS1 ordered sets (16 symbols),
// - logical idle (0x00).
// SKP and TS1 are only inserted at packet boundaries. SKP outranks TS1.
module tx_symbol_scheduler #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_COUNT    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  input  logic       ts_req_i,
  input  logic [7:0] link_num_i,
  input  logic [7:0] lane_num_i,
  input  logic [7:0] n_fts_i,
  output logic       ts_done_o,
  output logic [7:0] sym_o,
  output logic       sym_k_o,
  output logic       underflow_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_SKP  = 2'd2;
  localparam logic [1:0] ST_TS1  = 2'd3;

  localparam logic [7:0] SYM_COM    = 8'hBC;
  localparam logic [7:0] SYM_SKP    = 8'h1C;
  localparam logic [7:0] SYM_TS1_ID = 8'h4A;
  localparam logic [7:0] SYM_RATE   = 8'h02;
  localparam logic [7:0] SYM_IDLE   = 8'h00;

  localparam logic [11:0] SKP_WRAP = 12'(SKP_INTERVAL - 1);
  localparam logic [3:0]  SKP_LAST = 4'(SKP_COUNT);
  localparam logic [3:0]  TS1_LAST = 4'd15;

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  link_q, link_d;
  logic [7:0]  lane_q, lane_d;
  logic [7:0]  nfts_q, nfts_d;
  logic [11:0] skp_cnt_q, skp_cnt_d;
  logic        skp_pending_q, skp_pending_d;
  logic [7:0]  sym_q, sym_d;
  logic        sym_k_q, sym_k_d;
  logic        ts_done_q, ts_done_d;
  logic        underflow_q, underflow_d;

  logic skp_wrap;
  logic sel_skp;
  logic sel_ts1;

  // The arbitration decisions are only taken while IDLE, so an ordered set can never split a packet.
  assign sel_skp = (state_q == ST_IDLE) && skp_pending_q;
  assign sel_ts1 = (state_q == ST_IDLE) && !skp_pending_q && ts_req_i;

  // Free-running SKP interval counter. The pending flag holds at most one outstanding SKP set.
  always_comb begin
    skp_wrap      = (skp_cnt_q == SKP_WRAP);
    skp_cnt_d     = skp_wrap ? 12'd0 : skp_cnt_q + 12'd1;
    skp_pending_d = skp_pending_q;
    if (skp_wrap) begin
      skp_pending_d = 1'b1;
    end else if (sel_skp) begin
      skp_pending_d = 1'b0;
    end
  end

  // Upstream handshake. In IDLE, ready is withheld while an ordered set is about to be chosen.
  always_comb begin
    tx_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: tx_ready_o = !skp_pending_q && !ts_req_i;
      ST_DATA: tx_ready_o = 1'b1;
      default: tx_ready_o = 1'b0;
    endcase
  end

  // Next-state logic and selection of the symbol registered for the next cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    link_d      = link_q;
    lane_d      = lane_q;
    nfts_d      = nfts_q;
    sym_d       = SYM_IDLE;
    sym_k_d     = 1'b0;
    ts_done_d   = 1'b0;
    underflow_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_skp) begin
          sym_d   = SYM_COM;
          sym_k_d = 1'b1;
          idx_d   = 4'd1;
          state_d = ST_SKP;
        end else if (sel_ts1) begin
          sym_d   = SYM_COM;
          sym_k_d = 1'b1;
          idx_d   = 4'd1;
          link_d  = link_num_i;
          lane_d  = lane_num_i;
          nfts_d  = n_fts_i;
          state_d = ST_TS1;
        end else if (tx_valid_i) begin
          sym_d   = tx_data_i;
          state_d = tx_last_i ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_valid_i) begin
          sym_d = tx_data_i;
          if (tx_last_i) begin
            state_d = ST_IDLE;
          end
        end else begin
          // Starved mid-packet: fill with a zero data symbol and flag it.
          underflow_d = 1'b1;
        end
      end
      ST_SKP: begin
        sym_d   = SYM_SKP;
        sym_k_d = 1'b1;
        if (idx_q == SKP_LAST) begin
          idx_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_TS1: begin
        case (idx_q)
          4'd1:    sym_d = link_q;
          4'd2:    sym_d = lane_q;
          4'd3:    sym_d = nfts_q;
          4'd4:    sym_d = SYM_RATE;
          4'd5:    sym_d = 8'h00;
          default: sym_d = SYM_TS1_ID;
        endcase
        if (idx_q == TS1_LAST) begin
          ts_done_d = 1'b1;
          idx_d     = 4'd0;
          state_d   = ST_IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // State and output registers. Reset abandons any sequence in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      idx_q         <= 4'd0;
      link_q        <= 8'h00;
      lane_q        <= 8'h00;
      nfts_q        <= 8'h00;
      skp_cnt_q     <= 12'd0;
      skp_pending_q <= 1'b0;
      sym_q         <= SYM_IDLE;
      sym_k_q       <= 1'b0;
      ts_done_q     <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      link_q        <= link_d;
      lane_q        <= lane_d;
      nfts_q        <= nfts_d;
      skp_cnt_q     <= skp_cnt_d;
      skp_pending_q <= skp_pending_d;
      sym_q         <= sym_d;
      sym_k_q       <= sym_k_d;
      ts_done_q     <= ts_done_d;
      underflow_q   <= underflow_d;
    end
  end

  assign sym_o       = sym_q;
  assign sym_k_o     = sym_k_q;
  assign ts_done_o   = ts_done_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Directed testbench for tx_symbol_scheduler.
// It runs with a short SKP interval (32) so that SKP insertion can be observed.
// Cycle numbering: E0 is the clock edge that samples reset. Ek is the k-th edge after E0.
module tb_tx_symbol_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       ts_req;
  logic [7:0] link_num;
  logic [7:0] lane_num;
  logic [7:0] n_fts;
  logic       ts_done;
  logic [7:0] sym;
  logic       sym_k;
  logic       underflow;

  int n_checks = 0;
  int n_fails  = 0;

  tx_symbol_scheduler #(
    .SKP_INTERVAL(32),
    .SKP_COUNT   (3)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_valid_i (tx_valid),
    .tx_data_i  (tx_data),
    .tx_last_i  (tx_last),
    .tx_ready_o (tx_ready),
    .ts_req_i   (ts_req),
    .link_num_i (link_num),
    .lane_num_i (lane_num),
    .n_fts_i    (n_fts),
    .ts_done_o  (ts_done),
    .sym_o      (sym),
    .sym_k_o    (sym_k),
    .underflow_o(underflow)
  );

  always #5 clk = ~clk;

  // Advance one edge. Registered outputs are sampled and inputs are driven 1 ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset stimulus. On return, the last edge (E0) has sampled reset.
  task automatic do_reset;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    ts_req   = 1'b0;
    link_num = 8'h00;
    lane_num = 8'h00;
    n_fts    = 8'h00;
    rst      = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    $display("[reset] sym=%02h k=%0b done=%0b uf=%0b rdy=%0b", sym, sym_k, ts_done, underflow, tx_ready);
    n_checks++;
    if ({sym_k, sym} !== 9'h000) begin
      n_fails++;
      $display("FAIL reset_sym: got %03h want 000", {sym_k, sym});
    end
    n_checks++;
    if (ts_done !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_done: got %0b want 0", ts_done);
    end
    n_checks++;
    if (underflow !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_uf: got %0b want 0", underflow);
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_ready: got %0b want 1", tx_ready);
    end
    ts_req = 1'b1;
    #1;
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_ready_tsreq: got %0b want 0", tx_ready);
    end
    ts_req = 1'b0;
  endtask

  // No traffic: the pending flag is set at E32, so COM appears at E33, followed by three SKPs. The period is 32.
  task automatic test_skp_interval;
    logic [8:0] exp_sym;
    logic       exp_rdy;
    do_reset;
    for (int k = 1; k <= 70; k++) begin
      tick;
      if (k == 33 || k == 65) exp_sym = 9'h1BC;
      else if ((k >= 34 && k <= 36) || (k >= 66 && k <= 68)) exp_sym = 9'h11C;
      else exp_sym = 9'h000;
      exp_rdy = !((k >= 32 && k <= 35) || (k >= 64 && k <= 67));
      if (exp_sym != 9'h000) $display("[skp] E%0d sym=%02h k=%0b rdy=%0b", k, sym, sym_k, tx_ready);
      n_checks++;
      if ({sym_k, sym} !== exp_sym) begin
        n_fails++;
        $display("FAIL skp_sym E%0d: got %03h want %03h", k, {sym_k, sym}, exp_sym);
      end
      n_checks++;
      if (tx_ready !== exp_rdy) begin
        n_fails++;
        $display("FAIL skp_ready E%0d: got %0b want %0b", k, tx_ready, exp_rdy);
      end
    end
  endtask

  // TS1 with fields 05/01/20. The fields are changed after capture to show they are snapshotted.
  task automatic test_ts1;
    logic [8:0] exp_tab [0:16];
    exp_tab = '{9'h1BC, 9'h005, 9'h001, 9'h020, 9'h002, 9'h000,
                9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A,
                9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h000};
    do_reset;
    ts_req   = 1'b1;
    link_num = 8'h05;
    lane_num = 8'h01;
    n_fts    = 8'h20;
    #1;
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL ts1_ready: got %0b want 0", tx_ready);
    end
    for (int k = 1; k <= 17; k++) begin
      tick;
      $display("[ts1] E%0d sym=%02h k=%0b done=%0b", k, sym, sym_k, ts_done);
      n_checks++;
      if ({sym_k, sym} !== exp_tab[k-1]) begin
        n_fails++;
        $display("FAIL ts1_sym E%0d: got %03h want %03h", k, {sym_k, sym}, exp_tab[k-1]);
      end
      n_checks++;
      if (ts_done !== (k == 16)) begin
        n_fails++;
        $display("FAIL ts1_done E%0d: got %0b want %0b", k, ts_done, (k == 16));
      end
      if (k == 1) begin
        link_num = 8'hFF;
        lane_num = 8'hFF;
        n_fts    = 8'hFF;
      end
      if (k == 16) ts_req = 1'b0;
    end
  endtask

  // If the request is still held after ts_done, a second TS1 starts immediately.
  task automatic test_ts_back_to_back;
    logic [8:0] exp_sym;
    int         idx;
    do_reset;
    ts_req   = 1'b1;
    link_num = 8'h11;
    lane_num = 8'h22;
    n_fts    = 8'h33;
    for (int k = 1; k <= 32; k++) begin
      tick;
      idx = (k - 1) % 16;
      case (idx)
        0:       exp_sym = 9'h1BC;
        1:       exp_sym = 9'h011;
        2:       exp_sym = 9'h022;
        3:       exp_sym = 9'h033;
        4:       exp_sym = 9'h002;
        5:       exp_sym = 9'h000;
        default: exp_sym = 9'h04A;
      endcase
      if (idx == 0 || idx == 15) $display("[b2b] E%0d sym=%02h k=%0b done=%0b", k, sym, sym_k, ts_done);
      n_checks++;
      if ({sym_k, sym} !== exp_sym) begin
        n_fails++;
        $display("FAIL b2b_sym E%0d: got %03h want %03h", k, {sym_k, sym}, exp_sym);
      end
      n_checks++;
      if (ts_done !== (idx == 15)) begin
        n_fails++;
        $display("FAIL b2b_done E%0d: got %0b want %0b", k, ts_done, (idx == 15));
      end
    end
    ts_req = 1'b0;
  endtask

  // Packet A1..A4 straddles the SKP trigger at E32. SKP waits for the packet end.
  // A short TS1 request pulse during the packet is ignored.
  task automatic test_skp_during_packet;
    logic [8:0] exp_sym [0:9];
    logic       exp_rdy [0:9];
    exp_sym = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h1BC,
                9'h11C, 9'h11C, 9'h11C, 9'h000, 9'h000};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset;
    for (int k = 1; k <= 30; k++) tick;
    tx_valid = 1'b1;
    tx_data  = 8'hA1;
    tx_last  = 1'b0;
    #1;
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL pkt_ready_start: got %0b want 1", tx_ready);
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      $display("[pkt] E%0d sym=%02h k=%0b rdy=%0b", 31 + i, sym, sym_k, tx_ready);
      n_checks++;
      if ({sym_k, sym} !== exp_sym[i]) begin
        n_fails++;
        $display("FAIL pkt_sym E%0d: got %03h want %03h", 31 + i, {sym_k, sym}, exp_sym[i]);
      end
      n_checks++;
      if (tx_ready !== exp_rdy[i]) begin
        n_fails++;
        $display("FAIL pkt_ready E%0d: got %0b want %0b", 31 + i, tx_ready, exp_rdy[i]);
      end
      case (i)
        0: begin tx_data = 8'hA2; ts_req = 1'b1; end
        1: begin tx_data = 8'hA3; ts_req = 1'b0; end
        2: begin tx_data = 8'hA4; tx_last = 1'b1; end
        3: begin tx_valid = 1'b0; tx_last = 1'b0; end
        default: ;
      endcase
    end
  endtask

  // Two starved cycles mid-packet produce two zero fill symbols and two underflow pulses.
  task automatic test_underflow;
    logic [8:0] exp_sym [0:4];
    logic       exp_uf  [0:4];
    exp_sym = '{9'h0B1, 9'h000, 9'h000, 9'h0B2, 9'h000};
    exp_uf  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset;
    tx_valid = 1'b1;
    tx_data  = 8'hB1;
    tx_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      $display("[uf] E%0d sym=%02h k=%0b uf=%0b rdy=%0b", i + 1, sym, sym_k, underflow, tx_ready);
      n_checks++;
      if ({sym_k, sym} !== exp_sym[i]) begin
        n_fails++;
        $display("FAIL uf_sym E%0d: got %03h want %03h", i + 1, {sym_k, sym}, exp_sym[i]);
      end
      n_checks++;
      if (underflow !== exp_uf[i]) begin
        n_fails++;
        $display("FAIL uf_pulse E%0d: got %0b want %0b", i + 1, underflow, exp_uf[i]);
      end
      n_checks++;
      if (tx_ready !== 1'b1) begin
        n_fails++;
        $display("FAIL uf_ready E%0d: got %0b want 1", i + 1, tx_ready);
      end
      case (i)
        0: tx_valid = 1'b0;
        2: begin tx_valid = 1'b1; tx_data = 8'hB2; tx_last = 1'b1; end
        3: begin tx_valid = 1'b0; tx_last = 1'b0; end
        default: ;
      endcase
    end
  endtask

  // SKP is pending together with a TS1 request: the SKP set goes first, then TS1. Ready stays low throughout.
  task automatic test_both_pending;
    logic [8:0] exp_sym;
    int         idx;
    do_reset;
    for (int k = 1; k <= 32; k++) tick;
    ts_req   = 1'b1;
    link_num = 8'h05;
    lane_num = 8'h01;
    n_fts    = 8'h20;
    #1;
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL both_ready_E32: got %0b want 0", tx_ready);
    end
    for (int k = 33; k <= 53; k++) begin
      tick;
      if (k == 33 || k == 37) exp_sym = 9'h1BC;
      else if (k >= 34 && k <= 36) exp_sym = 9'h11C;
      else if (k == 53) exp_sym = 9'h000;
      else begin
        idx = k - 37;
        case (idx)
          1:       exp_sym = 9'h005;
          2:       exp_sym = 9'h001;
          3:       exp_sym = 9'h020;
          4:       exp_sym = 9'h002;
          5:       exp_sym = 9'h000;
          default: exp_sym = 9'h04A;
        endcase
      end
      $display("[both] E%0d sym=%02h k=%0b done=%0b rdy=%0b", k, sym, sym_k, ts_done, tx_ready);
      n_checks++;
      if ({sym_k, sym} !== exp_sym) begin
        n_fails++;
        $display("FAIL both_sym E%0d: got %03h want %03h", k, {sym_k, sym}, exp_sym);
      end
      n_checks++;
      if (ts_done !== (k == 52)) begin
        n_fails++;
        $display("FAIL both_done E%0d: got %0b want %0b", k, ts_done, (k == 52));
      end
      if (k <= 52) begin
        n_checks++;
        if (tx_ready !== 1'b0) begin
          n_fails++;
          $display("FAIL both_ready E%0d: got %0b want 0", k, tx_ready);
        end
      end
      if (k == 52) ts_req = 1'b0;
    end
  endtask

  // A reset in the middle of TS1 kills the set. The SKP counter restarts, so the next COM appears 33 edges later.
  task automatic test_reset_mid_ts1;
    logic [8:0] exp_sym;
    do_reset;
    ts_req   = 1'b1;
    link_num = 8'h05;
    lane_num = 8'h01;
    n_fts    = 8'h20;
    for (int k = 1; k <= 7; k++) tick;
    rst    = 1'b1;
    ts_req = 1'b0;
    tick;
    rst = 1'b0;
    $display("[rst_ts1] E8 sym=%02h k=%0b done=%0b rdy=%0b", sym, sym_k, ts_done, tx_ready);
    n_checks++;
    if ({sym_k, sym} !== 9'h000) begin
      n_fails++;
      $display("FAIL rst_ts1_sym: got %03h want 000", {sym_k, sym});
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL rst_ts1_ready: got %0b want 1", tx_ready);
    end
    for (int k = 9; k <= 41; k++) begin
      tick;
      exp_sym = (k == 41) ? 9'h1BC : 9'h000;
      if (k == 41) $display("[rst_ts1] E%0d sym=%02h k=%0b", k, sym, sym_k);
      n_checks++;
      if ({sym_k, sym} !== exp_sym) begin
        n_fails++;
        $display("FAIL rst_ts1_sym E%0d: got %03h want %03h", k, {sym_k, sym}, exp_sym);
      end
      n_checks++;
      if (ts_done !== 1'b0) begin
        n_fails++;
        $display("FAIL rst_ts1_done E%0d: got %0b want 0", k, ts_done);
      end
    end
  endtask

  initial begin
    test_reset;
    test_skp_interval;
    test_ts1;
    test_ts_back_to_back;
    test_skp_during_packet;
    test_underflow;
    test_both_pending;
    test_reset_mid_ts1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
